// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: funct3 codes, writeback-select and FSM enums, access-size decode for the MEM stage
package mem_stage_pkg;
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   typedef enum logic [1:0] {WB_ALU = 2'b00, WB_MEM = 2'b01, WB_PC4 = 2'b10} wb_sel_t;
   typedef enum logic [1:0] {IDLE, REQ, RESP} mem_state_t;
   typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;
   // Unsigned variants only exist for loads; anything unrecognised is a word access
   function automatic size_t access_size(input logic [2:0] funct3, input logic we);
      if (funct3 == F3_B || (!we && funct3 == F3_BU)) return SZ_B;
      if (funct3 == F3_H || (!we && funct3 == F3_HU)) return SZ_H;
      return SZ_W;
   endfunction
   function automatic logic misaligned(input logic [2:0] funct3, input logic we, input logic [1:0] off);
      size_t s;
      s = access_size(funct3, we);
      return (s == SZ_H) ? off[0] : (s == SZ_W) ? (off != 2'b00) : 1'b0;
   endfunction
endpackage

// File: rtl/memory_stage_align.sv
// load_store_align: store byte-lane/data placement and load byte/half extraction with extension
module load_store_align
   import mem_stage_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2:0]      funct3,
   input  logic [1:0]      off,
   input  logic            we,
   input  logic [XLEN-1:0] rs2,
   input  logic [2:0]      ld_funct3,
   input  logic [1:0]      ld_off,
   input  logic [XLEN-1:0] rdata,
   output logic [3:0]      be,
   output logic [XLEN-1:0] wdata,
   output logic [XLEN-1:0] load_data
);
   size_t st_size;
   logic [7:0] byte_v;
   logic [15:0] half_v;
   assign st_size = access_size(funct3, we);
   assign byte_v = rdata[8*ld_off +: 8];
   assign half_v = rdata[16*ld_off[1] +: 16];
   // Store lanes: shifted enables drop anything past the top of the word
   always_comb begin
      be = !we ? 4'hF : (st_size == SZ_B) ? 4'b0001 << off : (st_size == SZ_H) ? 4'b0011 << off : 4'hF;
      wdata = (st_size == SZ_B) ? {4{rs2[7:0]}} : (st_size == SZ_H) ? {2{rs2[15:0]}} : rs2;
   end
   // Load extension by funct3; unknown codes pass the full word
   always_comb
      load_data = (ld_funct3 == F3_B)  ? {{(XLEN-8){byte_v[7]}}, byte_v} :
                  (ld_funct3 == F3_BU) ? {{(XLEN-8){1'b0}}, byte_v} :
                  (ld_funct3 == F3_H)  ? {{(XLEN-16){half_v[15]}}, half_v} :
                  (ld_funct3 == F3_HU) ? {{(XLEN-16){1'b0}}, half_v} : rdata;
endmodule

// File: rtl/memory_stage.sv
// memory_stage: MEM pipeline stage -- data-memory req/gnt/rvalid FSM, lane alignment, MEM/WB register.
// Optional macro MISALIGN_TRAP_EN: misaligned half/word accesses skip the bus and flag misalign_MEMWB.
module memory_stage
   import mem_stage_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [XLEN-1:0]   ALU_out_EXMEM,
   input  logic [2:0]        funct3_EXMEM,
   input  logic              mem_wr_en_EXMEM,
   input  logic [XLEN-1:0]   rs2_data_EXMEM,
   input  logic              reg_wr_en_EXMEM,
   input  logic [1:0]        reg_wr_ctrl_EXMEM,
   input  logic [4:0]        rd_EXMEM,
   input  logic [XLEN-1:0]   pc_4_EXMEM,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [XLEN-1:0]   dmem_wdata,
   output logic [3:0]        dmem_be,
   input  logic              dmem_gnt,
   input  logic              dmem_rvalid,
   input  logic [XLEN-1:0]   dmem_rdata,
   output logic              stall_MEM,
   output logic [XLEN-1:0]   reg_wr_data_MEMWB,
   output logic [4:0]        rd_MEMWB,
   output logic              reg_wr_en_MEMWB,
   output logic              misalign_MEMWB
);
   mem_state_t state, state_next;
   logic access, trap, active, done, idle;
   logic [ADDR_W-1:0] addr_q;
   logic we_q;
   logic [XLEN-1:0] wdata_q, wdata_c, load_data, wb_data;
   logic [3:0] be_q, be_c;
   logic [2:0] funct3_q, ld_funct3;
   logic [1:0] off_q, ld_off;

   assign access = mem_wr_en_EXMEM | (reg_wr_ctrl_EXMEM == WB_MEM);
   assign idle = (state == IDLE);
`ifdef MISALIGN_TRAP_EN
   assign trap = idle & access & misaligned(funct3_EXMEM, mem_wr_en_EXMEM, ALU_out_EXMEM[1:0]);
`else
   assign trap = 1'b0;
`endif

   // In IDLE the bus sees the live request; afterwards the latched copy keeps it stable
   assign dmem_addr  = idle ? {ALU_out_EXMEM[ADDR_W-1:2], 2'b00} : addr_q;
   assign dmem_we    = idle ? mem_wr_en_EXMEM : we_q;
   assign dmem_wdata = idle ? wdata_c : wdata_q;
   assign dmem_be    = idle ? be_c : be_q;
   assign ld_funct3  = idle ? funct3_EXMEM : funct3_q;
   assign ld_off     = idle ? ALU_out_EXMEM[1:0] : off_q;

   load_store_align #(.XLEN(XLEN)) u_align (
      .funct3    (funct3_EXMEM),
      .off       (ALU_out_EXMEM[1:0]),
      .we        (mem_wr_en_EXMEM),
      .rs2       (rs2_data_EXMEM),
      .ld_funct3 (ld_funct3),
      .ld_off    (ld_off),
      .rdata     (dmem_rdata),
      .be        (be_c),
      .wdata     (wdata_c),
      .load_data (load_data)
   );

   // State register
   always_ff @(posedge clk)
      if (reset) state <= IDLE;
      else state <= state_next;

   // Next state: a response arriving with the grant finishes the load at once
   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (access & ~trap) state_next = !dmem_gnt ? REQ : (mem_wr_en_EXMEM | dmem_rvalid) ? IDLE : RESP;
         REQ:  if (dmem_gnt) state_next = (we_q | dmem_rvalid) ? IDLE : RESP;
         RESP: if (dmem_rvalid) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Outputs: bus request and completion of the current op; stall until completion
   always_comb begin
      active = 1'b1;
      done = 1'b0;
      dmem_req = 1'b0;
      case (state)
         IDLE: begin
            active = access;
            dmem_req = access & ~trap & ~reset;
            done = ~access | trap | (dmem_gnt & (mem_wr_en_EXMEM | dmem_rvalid));
         end
         REQ: begin
            dmem_req = ~reset;
            done = dmem_gnt & (we_q | dmem_rvalid);
         end
         RESP: done = dmem_rvalid;
         default: done = 1'b1;
      endcase
      stall_MEM = ~reset & active & ~done;
   end

   // Request latch, refreshed whenever the FSM is idle
   always_ff @(posedge clk)
      if (reset) begin
         addr_q <= '0;
         we_q <= 1'b0;
         wdata_q <= '0;
         be_q <= '0;
         funct3_q <= '0;
         off_q <= '0;
      end else if (idle) begin
         addr_q <= {ALU_out_EXMEM[ADDR_W-1:2], 2'b00};
         we_q <= mem_wr_en_EXMEM;
         wdata_q <= wdata_c;
         be_q <= be_c;
         funct3_q <= funct3_EXMEM;
         off_q <= ALU_out_EXMEM[1:0];
      end

   // Writeback select; the reserved code yields zero
   always_comb
      wb_data = (reg_wr_ctrl_EXMEM == WB_ALU) ? ALU_out_EXMEM :
                (reg_wr_ctrl_EXMEM == WB_MEM) ? load_data :
                (reg_wr_ctrl_EXMEM == WB_PC4) ? pc_4_EXMEM : '0;

   // MEM/WB register: bubble while stalled, real result on the completing cycle
   always_ff @(posedge clk)
      if (reset) begin
         reg_wr_data_MEMWB <= '0;
         rd_MEMWB <= '0;
         reg_wr_en_MEMWB <= 1'b0;
         misalign_MEMWB <= 1'b0;
      end else if (stall_MEM) begin
         reg_wr_en_MEMWB <= 1'b0;
         misalign_MEMWB <= 1'b0;
      end else begin
         reg_wr_data_MEMWB <= wb_data;
         rd_MEMWB <= rd_EXMEM;
         reg_wr_en_MEMWB <= reg_wr_en_EXMEM & (reg_wr_ctrl_EXMEM != 2'b11) & ~trap;
         misalign_MEMWB <= trap;
      end
endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: scoreboard bench for memory_stage (honours MISALIGN_TRAP_EN if defined)
module tb_memory_stage;
   import mem_stage_pkg::*;
   logic clk = 1'b0, reset;
   logic [31:0] alu, rs2, pc4, rdata;
   logic [2:0] f3;
   logic mem_we, reg_en, gnt, rvalid;
   logic [1:0] ctrl;
   logic [4:0] rd;
   logic dmem_req, dmem_we, stall_MEM, reg_wr_en_MEMWB, misalign_MEMWB;
   logic [31:0] dmem_addr, dmem_wdata, reg_wr_data_MEMWB;
   logic [3:0] dmem_be;
   logic [4:0] rd_MEMWB;
   typedef struct {logic [31:0] data; logic [4:0] rd; logic en; logic chk; logic mis;} exp_t;
   exp_t sb[$];
   int checks = 0, failures = 0;
   localparam logic [2:0]  LF3 [7] = '{F3_H, F3_BU, F3_W, F3_B, F3_H, 3'b011, F3_B};
   localparam logic [31:0] LAD [7] = '{32'h2, 32'h1, 32'h0, 32'h3, 32'h0, 32'h4, 32'h0};
   localparam logic [31:0] LRD [7] = '{32'h80010000, 32'h0000F000, 32'hDEADBEEF, 32'h7F000000, 32'hFFFF7FFF, 32'hCAFEF00D, 32'h000000FF};
   localparam logic [31:0] LEX [7] = '{32'hFFFF8001, 32'h000000F0, 32'hDEADBEEF, 32'h0000007F, 32'h00007FFF, 32'hCAFEF00D, 32'hFFFFFFFF};

   always #5 clk = ~clk;

   memory_stage dut (
      .clk(clk), .reset(reset), .ALU_out_EXMEM(alu), .funct3_EXMEM(f3), .mem_wr_en_EXMEM(mem_we),
      .rs2_data_EXMEM(rs2), .reg_wr_en_EXMEM(reg_en), .reg_wr_ctrl_EXMEM(ctrl), .rd_EXMEM(rd),
      .pc_4_EXMEM(pc4), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_gnt(gnt), .dmem_rvalid(rvalid),
      .dmem_rdata(rdata), .stall_MEM(stall_MEM), .reg_wr_data_MEMWB(reg_wr_data_MEMWB),
      .rd_MEMWB(rd_MEMWB), .reg_wr_en_MEMWB(reg_wr_en_MEMWB), .misalign_MEMWB(misalign_MEMWB)
   );

   task automatic set_ex(input logic [2:0] f3_i, input logic we_i, input logic [31:0] rs2_i, input logic en_i,
                         input logic [1:0] ctrl_i, input logic [4:0] rd_i, input logic [31:0] alu_i, input logic [31:0] pc4_i);
      f3 = f3_i; mem_we = we_i; rs2 = rs2_i; reg_en = en_i; ctrl = ctrl_i; rd = rd_i; alu = alu_i; pc4 = pc4_i;
   endtask

   task automatic nop();
      set_ex(3'b000, 1'b0, 32'h0, 1'b0, 2'b00, 5'd0, 32'h0, 32'h0);
   endtask

   // Generic access with a bus model granting after gd cycles and answering rd_dly cycles after the grant
   task automatic access_op(input string name, input logic we_i, input logic [2:0] f3_i, input logic [31:0] addr_i,
                            input logic [31:0] rs2_i, input logic [31:0] rdata_i, input logic [4:0] rd_i,
                            input int gd, input int rd_dly, input logic [3:0] be_x, input logic [31:0] wdata_x,
                            input logic [31:0] data_x);
      exp_t e;
      int lat, stalls;
      bit fin;
      lat = we_i ? gd + 1 : gd + rd_dly + 1;
      stalls = 0;
      fin = 1'b0;
      set_ex(f3_i, we_i, rs2_i, !we_i, we_i ? 2'b00 : 2'b01, rd_i, addr_i, 32'h0);
      sb.push_back('{data: data_x, rd: rd_i, en: !we_i, chk: !we_i, mis: 1'b0});
      for (int c = 0; c < 20 && !fin; c++) begin
         gnt = (c == gd);
         rvalid = !we_i && (c == gd + rd_dly);
         rdata = rdata_i;
         @(negedge clk);
         checks++;
         if (c <= gd) begin
            if (dmem_req !== 1'b1 || dmem_we !== we_i || dmem_addr !== {addr_i[31:2], 2'b00} || dmem_be !== be_x || (we_i && dmem_wdata !== wdata_x)) begin
               failures++;
               $display("FAIL %s bus c=%0d got req=%b we=%b addr=%h be=%b wdata=%h expected req=1 we=%b addr=%h be=%b wdata=%h",
                        name, c, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, we_i, {addr_i[31:2], 2'b00}, be_x, wdata_x);
            end
         end else if (dmem_req !== 1'b0) begin
            failures++;
            $display("FAIL %s req_after_gnt c=%0d got req=%b expected 0", name, c, dmem_req);
         end
         fin = !stall_MEM;
         if (!fin) stalls++;
         @(posedge clk); #1;
      end
      gnt = 1'b0;
      rvalid = 1'b0;
      nop();
      checks++;
      if (!fin || stalls != lat - 1) begin
         failures++;
         $display("FAIL %s latency got stall_cycles=%0d done=%b expected stall_cycles=%0d", name, stalls, fin, lat - 1);
      end
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (reg_wr_en_MEMWB !== e.en || rd_MEMWB !== e.rd || misalign_MEMWB !== e.mis || (e.chk && reg_wr_data_MEMWB !== e.data)) begin
         failures++;
         $display("FAIL %s wb got en=%b rd=%0d mis=%b data=%h expected en=%b rd=%0d mis=%b data=%h",
                  name, reg_wr_en_MEMWB, rd_MEMWB, misalign_MEMWB, reg_wr_data_MEMWB, e.en, e.rd, e.mis, e.data);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      set_ex(F3_W, 1'b0, 32'h0, 1'b1, 2'b01, 5'd9, 32'h10, 32'h0);
      gnt = 1'b1;
      rvalid = 1'b1;
      @(negedge clk);
      checks++;
      if ({dmem_req, stall_MEM, reg_wr_en_MEMWB, misalign_MEMWB, rd_MEMWB, reg_wr_data_MEMWB} !== '0) begin
         failures++;
         $display("FAIL reset got req=%b stall=%b en=%b mis=%b rd=%0d data=%h expected all 0",
                  dmem_req, stall_MEM, reg_wr_en_MEMWB, misalign_MEMWB, rd_MEMWB, reg_wr_data_MEMWB);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      nop();
      @(negedge clk);
      checks++;
      if (dmem_req !== 1'b0 || stall_MEM !== 1'b0) begin
         failures++;
         $display("FAIL spurious_idle got req=%b stall=%b expected 0 0", dmem_req, stall_MEM);
      end
      @(posedge clk); #1;
      gnt = 1'b0;
      rvalid = 1'b0;
   endtask

   // ALU result then reserved WB select, issued back to back
   task automatic test_back_to_back();
      exp_t e;
      set_ex(F3_W, 1'b0, 32'h0, 1'b1, 2'b00, 5'd5, 32'h1234, 32'h0);
      sb.push_back('{data: 32'h1234, rd: 5'd5, en: 1'b1, chk: 1'b1, mis: 1'b0});
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if (stall_MEM !== 1'b0 || dmem_req !== 1'b0) begin
            failures++;
            $display("FAIL passthru_stall op=%0d got stall=%b req=%b expected 0 0", i, stall_MEM, dmem_req);
         end
         @(posedge clk); #1;
         if (i == 0) begin
            set_ex(F3_W, 1'b0, 32'h0, 1'b1, 2'b11, 5'd6, 32'hFFFF, 32'h4);
            sb.push_back('{data: 32'h0, rd: 5'd6, en: 1'b0, chk: 1'b1, mis: 1'b0});
         end else nop();
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if (reg_wr_en_MEMWB !== e.en || rd_MEMWB !== e.rd || misalign_MEMWB !== e.mis || (e.chk && reg_wr_data_MEMWB !== e.data)) begin
            failures++;
            $display("FAIL passthru_wb op=%0d got en=%b rd=%0d mis=%b data=%h expected en=%b rd=%0d mis=%b data=%h",
                     i, reg_wr_en_MEMWB, rd_MEMWB, misalign_MEMWB, reg_wr_data_MEMWB, e.en, e.rd, e.mis, e.data);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_jal();
      exp_t e;
      set_ex(F3_W, 1'b0, 32'h0, 1'b1, 2'b10, 5'd1, 32'h999, 32'h44);
      sb.push_back('{data: 32'h44, rd: 5'd1, en: 1'b1, chk: 1'b1, mis: 1'b0});
      @(posedge clk); #1;
      nop();
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (reg_wr_en_MEMWB !== e.en || rd_MEMWB !== e.rd || (e.chk && reg_wr_data_MEMWB !== e.data)) begin
         failures++;
         $display("FAIL jal_wb got en=%b rd=%0d data=%h expected en=%b rd=%0d data=%h",
                  reg_wr_en_MEMWB, rd_MEMWB, reg_wr_data_MEMWB, e.en, e.rd, e.data);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_store_lanes();
      access_op("sb_103", 1'b1, F3_B, 32'h103, 32'h000000A5, 32'h0, 5'd2, 0, 0, 4'b1000, 32'hA5A5A5A5, 32'h0);
      access_op("sb_201", 1'b1, F3_B, 32'h201, 32'h12345678, 32'h0, 5'd2, 1, 0, 4'b0010, 32'h78787878, 32'h0);
      access_op("sh_002", 1'b1, F3_H, 32'h2, 32'h1234ABCD, 32'h0, 5'd2, 0, 0, 4'b1100, 32'hABCDABCD, 32'h0);
      access_op("sh_000", 1'b1, F3_H, 32'h0, 32'h00005555, 32'h0, 5'd2, 1, 0, 4'b0011, 32'h55555555, 32'h0);
      access_op("sw_010", 1'b1, F3_W, 32'h10, 32'hCAFEBABE, 32'h0, 5'd2, 2, 0, 4'hF, 32'hCAFEBABE, 32'h0);
      access_op("s_undef", 1'b1, 3'b101, 32'h20, 32'h0BADF00D, 32'h0, 5'd2, 0, 0, 4'hF, 32'h0BADF00D, 32'h0);
`ifndef MISALIGN_TRAP_EN
      access_op("sh_003", 1'b1, F3_H, 32'h3, 32'h1234ABCD, 32'h0, 5'd2, 0, 0, 4'b1000, 32'hABCDABCD, 32'h0);
`endif
   endtask

   task automatic test_load_latency();
      access_op("lb_102", 1'b0, F3_B, 32'h102, 32'h0, 32'h0080FF00, 5'd7, 0, 3, 4'hF, 32'h0, 32'hFFFFFF80);
      access_op("lhu_002", 1'b0, F3_HU, 32'h2, 32'h0, 32'hBEEF0000, 5'd8, 2, 1, 4'hF, 32'h0, 32'h0000BEEF);
   endtask

   task automatic test_load_extend();
      for (int i = 0; i < 7; i++)
         access_op($sformatf("load_%0d", i), 1'b0, LF3[i], LAD[i], 32'h0, LRD[i], 5'(10 + i),
                   int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 4'hF, 32'h0, LEX[i]);
   endtask

   task automatic test_reset_resp();
      set_ex(F3_W, 1'b0, 32'h0, 1'b1, 2'b01, 5'd3, 32'h8, 32'h0);
      gnt = 1'b1;
      @(posedge clk); #1;
      gnt = 1'b0;
      @(negedge clk);
      checks++;
      if (stall_MEM !== 1'b1 || dmem_req !== 1'b0) begin
         failures++;
         $display("FAIL resp_wait got stall=%b req=%b expected 1 0", stall_MEM, dmem_req);
      end
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      nop();
      @(negedge clk);
      checks++;
      if (stall_MEM !== 1'b0 || dmem_req !== 1'b0 || reg_wr_en_MEMWB !== 1'b0) begin
         failures++;
         $display("FAIL reset_resp got stall=%b req=%b en=%b expected 0 0 0", stall_MEM, dmem_req, reg_wr_en_MEMWB);
      end
      @(posedge clk); #1;
      access_op("lw_after_reset", 1'b0, F3_W, 32'hC, 32'h0, 32'h13579BDF, 5'd3, 0, 0, 4'hF, 32'h0, 32'h13579BDF);
   endtask

   task automatic test_misalign();
`ifdef MISALIGN_TRAP_EN
      exp_t e;
      set_ex(F3_W, 1'b0, 32'h0, 1'b1, 2'b01, 5'd4, 32'h6, 32'h0);
      sb.push_back('{data: 32'h0, rd: 5'd4, en: 1'b0, chk: 1'b0, mis: 1'b1});
      @(negedge clk);
      checks++;
      if (dmem_req !== 1'b0 || stall_MEM !== 1'b0) begin
         failures++;
         $display("FAIL trap_bus got req=%b stall=%b expected 0 0", dmem_req, stall_MEM);
      end
      @(posedge clk); #1;
      nop();
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (reg_wr_en_MEMWB !== e.en || misalign_MEMWB !== e.mis || rd_MEMWB !== e.rd) begin
         failures++;
         $display("FAIL trap_wb got en=%b mis=%b rd=%0d expected en=%b mis=%b rd=%0d",
                  reg_wr_en_MEMWB, misalign_MEMWB, rd_MEMWB, e.en, e.mis, e.rd);
      end
      @(posedge clk); #1;
`else
      access_op("lw_006", 1'b0, F3_W, 32'h6, 32'h0, 32'h11223344, 5'd4, 0, 0, 4'hF, 32'h0, 32'h11223344);
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1);
   end

   initial begin
      nop();
      gnt = 1'b0;
      rvalid = 1'b0;
      rdata = 32'h0;
      reset = 1'b1;
      @(posedge clk); #1;
      test_reset();
      test_back_to_back();
      test_jal();
      test_store_lanes();
      test_load_latency();
      test_load_extend();
      test_reset_resp();
      test_misalign();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
